nrzi_rx_deser: RTL and testbench

NRZI_RX_DESER -- requirements
Module: nrzi_rx_deser

---
 rtl/nrzi_rx_deser.sv | 170 +++++++++++++++++
 tb/tb_nrzi_rx_deser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_rx_deser.sv
// nrzi_rx_deser: NRZI decoder, sync hunter and byte deserializer with a one-byte output buffer.
// Optional NRZI_RX_PARITY_EN adds a 9th odd-parity bit per byte.  Rev 1.0
`default_nettype none

module nrzi_rx_deser #(
  parameter logic [7:0] SYNC_BYTE = 8'h7E,
  parameter int         FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_in,
  input  logic       bit_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sync_lock,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [0:0] S_HUNT = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;
`ifdef NRZI_RX_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif
  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

  logic [0:0] state_q, state_d;
  logic       prev_q, prev_d;
  logic [7:0] sh_q, sh_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       sync_lock_q, sync_lock_d;
  logic       overrun_q, overrun_d;

  logic       dec_bit;
  logic [7:0] sh_upd;
  logic [7:0] byte_val;
  logic       byte_done;
  logic       frame_done;

  assign dec_bit = line_in ^ prev_q;
  assign sh_upd  = {dec_bit, sh_q[7:1]};

`ifdef NRZI_RX_PARITY_EN
  // The 9th bit is parity, so the data byte is the register contents before it shifts in.
  assign byte_val = sh_q;
  logic parity_err_q, parity_err_d;
  always_comb begin
    parity_err_d = parity_err_q;
    if (byte_done && ((^sh_q) ^ dec_bit) == 1'b0) begin
      parity_err_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`else
  assign byte_val   = sh_upd;
  assign parity_err = 1'b0;
  logic sh_lsb_unused;
  assign sh_lsb_unused = sh_q[0];
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HUNT;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d    = state_q;
    byte_done  = 1'b0;
    frame_done = 1'b0;
    if (bit_en) begin
      case (state_q)
        S_HUNT: begin
          if (sh_upd == SYNC_BYTE) state_d = S_RECV;
        end
        S_RECV: begin
          if (bit_cnt_q == LAST_BIT) begin
            byte_done = 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              frame_done = 1'b1;
              state_d    = S_HUNT;
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  // FSM: outputs and datapath next values
  always_comb begin
    prev_d      = prev_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    sync_lock_d = (state_d == S_RECV);

    if (bit_en) begin
      prev_d = line_in;
      sh_d   = frame_done ? 8'h00 : sh_upd;
      if (state_q == S_HUNT) begin
        if (state_d == S_RECV) begin
          bit_cnt_d  = 4'd0;
          byte_cnt_d = 8'd0;
        end
      end else if (byte_done) begin
        bit_cnt_d  = 4'd0;
        byte_cnt_d = byte_cnt_q + 8'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end

    // A full buffer that is not being drained this cycle drops the new byte.
    if (byte_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = byte_val;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= 1'b0;
      sh_q        <= 8'h00;
      bit_cnt_q   <= 4'd0;
      byte_cnt_q  <= 8'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      sync_lock_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_lock_q <= sync_lock_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sync_lock = sync_lock_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_nrzi_rx_deser.sv
// tb_nrzi_rx_deser: directed NRZI stimulus with a byte scoreboard for nrzi_rx_deser.
// Honours NRZI_RX_PARITY_EN when defined.  Rev 1.0
`default_nettype none

module tb_nrzi_rx_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_in;
  logic       bit_en;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       sync_lock;
  logic       overrun;
  logic       parity_err;

  nrzi_rx_deser #(.SYNC_BYTE(8'h7E), .FRAME_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .bit_en     (bit_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sync_lock  (sync_lock),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic       line_lvl;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; each call consumes one edge.
  task automatic send_bit(input logic b);
    line_lvl = line_lvl ^ b;
    line_in  = line_lvl;
    bit_en   = 1'b1;
    @(posedge clk); #1;
    bit_en   = 1'b0;
  endtask

  task automatic send_bit_gap(input logic b);
    repeat ($urandom_range(0, 3)) begin
      line_in = 1'($urandom);
      @(posedge clk); #1;
    end
    send_bit(b);
  endtask

  task automatic send_raw8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    if (push) exp_q.push_back(b);
    send_raw8(b);
`ifdef NRZI_RX_PARITY_EN
    send_bit(~^b);
`endif
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) send_bit_gap(b[i]);
`ifdef NRZI_RX_PARITY_EN
    send_bit_gap(~^b);
`endif
  endtask

  // out_ready rises only for the edge that completes the byte.
  task automatic send_byte_late_ready(input logic [7:0] b);
    exp_q.push_back(b);
    for (int i = 0; i < 7; i++) send_bit(b[i]);
`ifdef NRZI_RX_PARITY_EN
    send_bit(b[7]);
    out_ready = 1'b1;
    send_bit(~^b);
`else
    out_ready = 1'b1;
    send_bit(b[7]);
`endif
  endtask

  // Handshake seen at the falling edge is the one the next rising edge performs.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk("stream_byte", out_data, mon_exp);
    end
  end

  initial begin
    rst = 1'b1; line_in = 1'b0; bit_en = 1'b0; out_ready = 1'b1; line_lvl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 8'h00);
    chk("rst_data", out_data, 8'h00);
    chk("rst_lock", sync_lock, 8'h00);
    chk("rst_overrun", overrun, 8'h00);
    chk("rst_parity", parity_err, 8'h00);
    rst = 1'b0;

    // Sync then first payload byte
    send_raw8(8'h7E);
    chk("lock_after_sync", sync_lock, 8'h01);
    send_byte(8'hA5, 1'b1);
    chk("a5_valid", out_valid, 8'h01);
    chk("a5_data", out_data, 8'hA5);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    chk("lock_before_end", sync_lock, 8'h01);
    send_byte(8'h30, 1'b1);
    chk("lock_after_frame", sync_lock, 8'h00);

    // Full frame, then data outside a frame must be ignored
    send_raw8(8'h7E);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    chk("lock_byte3", sync_lock, 8'h01);
    send_byte(8'h04, 1'b1);
    chk("lock_byte4", sync_lock, 8'h00);
    chk("b4_data", out_data, 8'h04);
    send_byte(8'h55, 1'b0);
    chk("hunt_no_valid1", out_valid, 8'h00);
    send_byte(8'h55, 1'b0);
    chk("hunt_no_valid2", out_valid, 8'h00);

    // Accept and completion in the same cycle
    send_raw8(8'h7E);
    out_ready = 1'b0;
    send_byte(8'h33, 1'b1);
    chk("hold_33", out_data, 8'h33);
    send_byte_late_ready(8'h44);
    chk("simul_valid", out_valid, 8'h01);
    chk("simul_data", out_data, 8'h44);
    chk("simul_overrun", overrun, 8'h00);

    // Backpressure drops the second byte
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    chk("bp_valid", out_valid, 8'h01);
    chk("bp_data", out_data, 8'h11);
    chk("bp_overrun", overrun, 8'h01);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 8'h00);
    chk("bp_overrun_sticky", overrun, 8'h01);

    // Random bit_en gaps with line noise while idle
    send_raw8(8'h7E);
    send_byte_gap(8'hC3);
    send_byte_gap(8'h5A);
    send_byte_gap(8'h0F);
    send_byte_gap(8'hF0);
    chk("gap_lock_end", sync_lock, 8'h00);
    @(posedge clk); #1;

    // Reset mid-byte with a buffered byte pending
    send_raw8(8'h7E);
    out_ready = 1'b0;
    send_byte(8'h99, 1'b0);
    chk("pre_rst_valid", out_valid, 8'h01);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1; bit_en = 1'b1; line_lvl = 1'b0; line_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bit_en = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", out_valid, 8'h00);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_lock", sync_lock, 8'h00);
    chk("mid_rst_overrun", overrun, 8'h00);
    send_byte(8'hA5, 1'b0);
    chk("post_rst_hunt", out_valid, 8'h00);

`ifdef NRZI_RX_PARITY_EN
    send_raw8(8'h7E);
    exp_q.push_back(8'h03);
    send_raw8(8'h03);
    send_bit(1'b1);
    chk("par_ok_err", parity_err, 8'h00);
    exp_q.push_back(8'h03);
    send_raw8(8'h03);
    send_bit(1'b0);
    chk("par_bad_err", parity_err, 8'h01);
    chk("par_bad_valid", out_valid, 8'h01);
    chk("par_bad_data", out_data, 8'h03);
`else
    chk("parity_tied", parity_err, 8'h00);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
